// File: rtl/scrambler.sv
// Per-lane PIPE scrambler: 8b/10b LFSR for Gen1/2, 128b/130b block-aware LFSR for Gen3+.
// Up to four bytes per cycle are processed in order through one shared LFSR state.
module scrambler (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  GEN,
    input  logic [5:0]  PIPEWIDTH,
    input  logic        turnOff,
    input  logic [23:0] seedValue,
    input  logic        PIPEDataValid,
    input  logic [31:0] PIPEData,
    input  logic [3:0]  PIPEDataK,
    input  logic [1:0]  PIPESyncHeader,
    output logic        scramblerDataValid,
    output logic [31:0] scramblerData,
    output logic [3:0]  scramblerDataK,
    output logic [1:0]  scramblerSyncHeader
);

    localparam int unsigned LFSR_W  = 23;
    localparam int unsigned NBYTES  = 4;
    localparam int unsigned STEP_W  = LFSR_W + 8;

    localparam logic [LFSR_W-1:0] TAPS16 = 23'h000039;
    localparam logic [LFSR_W-1:0] TAPS23 = 23'h210125;
    localparam logic [LFSR_W-1:0] INIT16 = 23'h00FFFF;

    localparam logic [7:0] K_COM  = 8'hBC;
    localparam logic [7:0] K_SKP  = 8'h1C;
    localparam logic [7:0] OS_EIE = 8'h00;
    localparam logic [7:0] OS_SKP = 8'hAA;
    localparam logic [1:0] HDR_OS = 2'b01;

    // Eight Galois shifts; returns {scramble mask (bit 0 first), next state}.
    function automatic logic [STEP_W-1:0] lfsr_step8(input logic [LFSR_W-1:0] s,
                                                     input logic m128);
        logic [LFSR_W-1:0] st;
        logic [7:0]        mask;
        logic              fb;
        st   = s;
        mask = '0;
        for (int i = 0; i < 8; i++) begin
            fb      = m128 ? st[22] : st[15];
            mask[i] = fb;
            if (m128)
                st = {st[21:0], 1'b0} ^ (fb ? TAPS23 : '0);
            else
                st = {7'd0, st[14:0], 1'b0} ^ (fb ? TAPS16 : '0);
        end
        return {mask, st};
    endfunction

    logic [LFSR_W-1:0] r_lfsr;
    logic [3:0]        r_cnt;
    logic [2:0]        r_gen_prev;
    logic              r_os;
    logic              r_os_skp;
    logic              r_os_eie;

    logic              w_m128;
    logic              w_gen_change;
    logic [LFSR_W-1:0] w_init;
    logic [2:0]        w_nbytes;
    logic [LFSR_W-1:0] w_lfsr_nxt;
    logic [3:0]        w_cnt_nxt;
    logic              w_os_nxt;
    logic              w_skp_nxt;
    logic              w_eie_nxt;
    logic [31:0]       w_out;
    logic [7:0]        w_byte;
    logic [STEP_W-1:0] w_step;

    assign w_m128       = (GEN >= 3'd3);
    assign w_gen_change = (GEN != r_gen_prev);
    assign w_init       = w_m128 ? seedValue[LFSR_W-1:0] : INIT16;

    always_comb begin
        w_nbytes = 3'd1;
        if (PIPEWIDTH == 6'd32)
            w_nbytes = 3'd4;
        else if (PIPEWIDTH == 6'd16)
            w_nbytes = 3'd2;
    end

    // Sequential per-byte walk; a GEN change starts from the fresh mode state.
    always_comb begin
        w_lfsr_nxt = w_gen_change ? w_init : r_lfsr;
        w_cnt_nxt  = w_gen_change ? 4'd0 : r_cnt;
        w_os_nxt   = r_os;
        w_skp_nxt  = r_os_skp;
        w_eie_nxt  = r_os_eie;
        w_out      = '0;
        w_byte     = '0;
        w_step     = '0;
        if (turnOff) begin
            w_out = PIPEData;
        end else begin
            for (int b = 0; b < NBYTES; b++) begin
                if (3'(b) < w_nbytes) begin
                    w_byte = PIPEData[8*b +: 8];
                    w_step = lfsr_step8(w_lfsr_nxt, w_m128);
                    if (!w_m128) begin
                        if (PIPEDataK[b]) begin
                            w_out[8*b +: 8] = w_byte;
                            if (w_byte == K_COM)
                                w_lfsr_nxt = INIT16;
                            else if (w_byte != K_SKP)
                                w_lfsr_nxt = w_step[LFSR_W-1:0];
                        end else begin
                            w_out[8*b +: 8] = w_byte ^ w_step[STEP_W-1:LFSR_W];
                            w_lfsr_nxt      = w_step[LFSR_W-1:0];
                        end
                    end else begin
                        if (w_cnt_nxt == 4'd0) begin
                            w_os_nxt  = (PIPESyncHeader == HDR_OS);
                            w_skp_nxt = (w_byte == OS_SKP);
                            w_eie_nxt = (w_byte == OS_EIE);
                        end
                        if (w_os_nxt) begin
                            w_out[8*b +: 8] = w_byte;
                            if (!w_skp_nxt)
                                w_lfsr_nxt = w_step[LFSR_W-1:0];
                            if (w_eie_nxt && (w_cnt_nxt == 4'd15))
                                w_lfsr_nxt = seedValue[LFSR_W-1:0];
                        end else begin
                            w_out[8*b +: 8] = w_byte ^ w_step[STEP_W-1:LFSR_W];
                            w_lfsr_nxt      = w_step[LFSR_W-1:0];
                        end
                        w_cnt_nxt = w_cnt_nxt + 4'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scramblerDataValid  <= 1'b0;
            scramblerData       <= '0;
            scramblerDataK      <= '0;
            scramblerSyncHeader <= '0;
            r_lfsr              <= w_init;
            r_cnt               <= '0;
            r_gen_prev          <= GEN;
            r_os                <= 1'b0;
            r_os_skp            <= 1'b0;
            r_os_eie            <= 1'b0;
        end else begin
            r_gen_prev         <= GEN;
            scramblerDataValid <= PIPEDataValid;
            if (PIPEDataValid) begin
                scramblerData       <= w_out;
                scramblerDataK      <= PIPEDataK;
                scramblerSyncHeader <= PIPESyncHeader;
            end
            if (PIPEDataValid && !turnOff) begin
                r_lfsr   <= w_lfsr_nxt;
                r_cnt    <= w_cnt_nxt;
                r_os     <= w_os_nxt;
                r_os_skp <= w_skp_nxt;
                r_os_eie <= w_eie_nxt;
            end else if (w_gen_change) begin
                r_lfsr <= w_init;
                r_cnt  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_scrambler.sv
// Self-checking bench for scrambler: directed vector table, corner sequences,
// and randomized traffic against a polynomial-level reference model.
module tb_scrambler;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  GEN;
    logic [5:0]  PIPEWIDTH;
    logic        turnOff;
    logic [23:0] seedValue;
    logic        PIPEDataValid;
    logic [31:0] PIPEData;
    logic [3:0]  PIPEDataK;
    logic [1:0]  PIPESyncHeader;
    logic        scramblerDataValid;
    logic [31:0] scramblerData;
    logic [3:0]  scramblerDataK;
    logic [1:0]  scramblerSyncHeader;

    scrambler dut (
        .clk                 (clk),
        .reset               (reset),
        .GEN                 (GEN),
        .PIPEWIDTH           (PIPEWIDTH),
        .turnOff             (turnOff),
        .seedValue           (seedValue),
        .PIPEDataValid       (PIPEDataValid),
        .PIPEData            (PIPEData),
        .PIPEDataK           (PIPEDataK),
        .PIPESyncHeader      (PIPESyncHeader),
        .scramblerDataValid  (scramblerDataValid),
        .scramblerData       (scramblerData),
        .scramblerDataK      (scramblerDataK),
        .scramblerSyncHeader (scramblerSyncHeader)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: polynomial exponents below the leading term.
    int          taps16[4] = '{0, 3, 4, 5};
    int          taps23[6] = '{0, 2, 5, 8, 16, 21};
    bit [22:0]   m_lfsr;
    int          m_cnt;
    bit          m_os, m_skp, m_eie;
    bit [2:0]    m_gen_prev;
    bit          e_valid;
    bit [31:0]   e_data;
    bit [3:0]    e_k;
    bit [1:0]    e_hdr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_shift8(input bit g3, output bit [7:0] mask);
        bit fb;
        int deg;
        deg = g3 ? 23 : 16;
        for (int i = 0; i < 8; i++) begin
            fb      = m_lfsr[deg-1];
            mask[i] = fb;
            m_lfsr  = m_lfsr << 1;
            if (!g3) m_lfsr = m_lfsr & 23'h00FFFF;
            if (fb) begin
                if (g3) foreach (taps23[j]) m_lfsr[taps23[j]] = ~m_lfsr[taps23[j]];
                else    foreach (taps16[j]) m_lfsr[taps16[j]] = ~m_lfsr[taps16[j]];
            end
        end
    endtask

    task automatic model_cycle(input bit rst, input bit [2:0] g, input bit [5:0] w,
                               input bit off, input bit [23:0] seed, input bit v,
                               input bit [31:0] d, input bit [3:0] k, input bit [1:0] h);
        bit        g3;
        bit [22:0] init;
        bit [7:0]  mask, by;
        int        n;
        g3   = (g >= 3);
        init = g3 ? seed[22:0] : 23'h00FFFF;
        if (rst) begin
            e_valid = 0; e_data = 0; e_k = 0; e_hdr = 0;
            m_lfsr = init; m_cnt = 0; m_gen_prev = g;
            m_os = 0; m_skp = 0; m_eie = 0;
            return;
        end
        if (g != m_gen_prev) begin
            m_lfsr = init;
            m_cnt  = 0;
        end
        m_gen_prev = g;
        e_valid    = v;
        if (!v) return;
        e_k   = k;
        e_hdr = h;
        if (off) begin
            e_data = d;
            return;
        end
        n      = (w == 32) ? 4 : (w == 16) ? 2 : 1;
        e_data = 0;
        for (int b = 0; b < n; b++) begin
            by = d[8*b +: 8];
            if (!g3) begin
                if (k[b] && by == 8'hBC) begin
                    e_data[8*b +: 8] = by;
                    m_lfsr = 23'h00FFFF;
                end else if (k[b] && by == 8'h1C) begin
                    e_data[8*b +: 8] = by;
                end else begin
                    model_shift8(0, mask);
                    e_data[8*b +: 8] = k[b] ? by : (by ^ mask);
                end
            end else begin
                if (m_cnt == 0) begin
                    m_os  = (h == 2'b01);
                    m_skp = (by == 8'hAA);
                    m_eie = (by == 8'h00);
                end
                if (m_os) begin
                    e_data[8*b +: 8] = by;
                    if (!m_skp) model_shift8(1, mask);
                    if (m_eie && m_cnt == 15) m_lfsr = seed[22:0];
                end else begin
                    model_shift8(1, mask);
                    e_data[8*b +: 8] = by ^ mask;
                end
                m_cnt = (m_cnt + 1) % 16;
            end
        end
    endtask

    // One clock: drive after negedge, update model at posedge, check #1 later.
    task automatic do_cycle(input bit rst, input bit v, input bit off,
                            input bit [31:0] d, input bit [3:0] k, input bit [1:0] h);
        @(negedge clk);
        reset = rst; turnOff = off; PIPEDataValid = v;
        PIPEData = d; PIPEDataK = k; PIPESyncHeader = h;
        @(posedge clk);
        model_cycle(rst, GEN, PIPEWIDTH, off, seedValue, v, d, k, h);
        #1;
        chk("valid", {31'd0, scramblerDataValid}, {31'd0, e_valid});
        chk("data",  scramblerData, e_data);
        chk("k",     {28'd0, scramblerDataK}, {28'd0, e_k});
        chk("hdr",   {30'd0, scramblerSyncHeader}, {30'd0, e_hdr});
    endtask

    typedef struct {
        bit        rst;
        bit [2:0]  gen;
        bit [5:0]  w;
        bit [3:0]  k;
        bit [31:0] d;
        bit [31:0] exp;
    } vec_t;

    vec_t tbl[16];
    bit [31:0] blk1[4];
    bit [31:0] rd;
    bit [5:0]  widths[3] = '{6'd8, 6'd16, 6'd32};

    initial begin
        reset = 1; GEN = 3'd1; PIPEWIDTH = 6'd8; turnOff = 0; seedValue = 24'h1DBFBC;
        PIPEDataValid = 0; PIPEData = 0; PIPEDataK = 0; PIPESyncHeader = 0;

        tbl[0]  = '{1, 3'd1, 6'd8,  4'b0000, 32'h00000000, 32'h00000000};
        tbl[1]  = '{0, 3'd1, 6'd8,  4'b0001, 32'h000000BC, 32'h000000BC};
        tbl[2]  = '{0, 3'd1, 6'd8,  4'b0000, 32'h00000000, 32'h000000FF};
        tbl[3]  = '{0, 3'd1, 6'd8,  4'b0000, 32'h00000000, 32'h00000017};
        tbl[4]  = '{0, 3'd1, 6'd8,  4'b0000, 32'h00000000, 32'h000000C0};
        tbl[5]  = '{0, 3'd1, 6'd8,  4'b0000, 32'h00000000, 32'h00000014};
        tbl[6]  = '{0, 3'd1, 6'd8,  4'b0001, 32'h000000BC, 32'h000000BC};
        tbl[7]  = '{0, 3'd1, 6'd8,  4'b0000, 32'h00000000, 32'h000000FF};
        tbl[8]  = '{0, 3'd1, 6'd8,  4'b0001, 32'h0000001C, 32'h0000001C};
        tbl[9]  = '{0, 3'd1, 6'd8,  4'b0000, 32'h00000000, 32'h00000017};
        tbl[10] = '{0, 3'd1, 6'd32, 4'b0001, 32'h000000BC, 32'hC017FFBC};
        tbl[11] = '{0, 3'd1, 6'd16, 4'b0001, 32'h000000BC, 32'h0000FFBC};
        tbl[12] = '{0, 3'd1, 6'd16, 4'b0000, 32'h00000000, 32'h0000C017};
        tbl[13] = '{0, 3'd1, 6'd16, 4'b0000, 32'hAAAA0000, 32'h0000B214};
        tbl[14] = '{0, 3'd2, 6'd8,  4'b0000, 32'h00000000, 32'h000000FF};
        tbl[15] = '{0, 3'd2, 6'd8,  4'b0000, 32'h00000000, 32'h00000017};

        for (int i = 0; i < 16; i++) begin
            GEN = tbl[i].gen; PIPEWIDTH = tbl[i].w;
            do_cycle(tbl[i].rst, !tbl[i].rst, 0, tbl[i].d, tbl[i].k, 2'b00);
            chk($sformatf("tbl%0d", i), scramblerData, tbl[i].exp);
        end

        // Bypass then resume: COM, bypassed words, idle gap, then D00 gives FF.
        do_cycle(0, 1, 0, 32'h000000BC, 4'b0001, 2'b00);
        PIPEWIDTH = 6'd32;
        for (int i = 0; i < 4; i++) begin
            rd = $urandom;
            do_cycle(0, 1, 1, rd, 4'($urandom), 2'b00);
            chk("bypass", scramblerData, rd);
        end
        do_cycle(0, 0, 0, 32'h12345678, 4'b0000, 2'b00);
        chk("gap_hold", scramblerData, rd);
        PIPEWIDTH = 6'd8;
        do_cycle(0, 1, 0, 32'h00000000, 4'b0000, 2'b00);
        chk("resume_ff", scramblerData, 32'h000000FF);

        // Gen3: data block, EIEOS block, data block must repeat the first.
        GEN = 3'd3; PIPEWIDTH = 6'd32; seedValue = 24'h1DBFBC;
        do_cycle(1, 0, 0, 0, 0, 2'b00);
        for (int i = 0; i < 4; i++) begin
            do_cycle(0, 1, 0, 32'h0, 4'b0, 2'b10);
            blk1[i] = e_data;
        end
        for (int i = 0; i < 4; i++) begin
            do_cycle(0, 1, 0, 32'hFF00FF00, 4'b0, 2'b01);
            chk("eieos_clear", scramblerData, 32'hFF00FF00);
        end
        for (int i = 0; i < 4; i++) begin
            do_cycle(0, 1, 0, 32'h0, 4'b0, 2'b10);
            chk("eieos_repeat", scramblerData, blk1[i]);
        end
        // SKP ordered set, then an invalid-header block scrambled like data.
        for (int i = 0; i < 4; i++) do_cycle(0, 1, 0, 32'hAAAAAAAA, 4'b0, 2'b01);
        for (int i = 0; i < 4; i++) do_cycle(0, 1, 0, 32'h0, 4'b0, 2'b11);

        // Reset at counter 7 mid-block; next block restarts from seed.
        PIPEWIDTH = 6'd8;
        for (int i = 0; i < 7; i++) do_cycle(0, 1, 0, 32'h5A, 4'b0, 2'b10);
        do_cycle(1, 1, 0, 32'h5A, 4'b0, 2'b10);
        chk("rst_mid_data", scramblerData, 32'h0);
        PIPEWIDTH = 6'd32;
        for (int i = 0; i < 4; i++) begin
            do_cycle(0, 1, 0, 32'h0, 4'b0, 2'b10);
            chk("rst_restart", scramblerData, blk1[i]);
        end

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            bit [31:0] d;
            bit [3:0]  k;
            if ($urandom_range(0, 39) == 0) GEN = 3'($urandom_range(1, 5));
            PIPEWIDTH = widths[$urandom_range(0, 2)];
            d = $urandom;
            k = 4'($urandom) & {4{$urandom_range(0, 3) == 0}};
            case ($urandom_range(0, 7))
                0: begin d[7:0] = 8'hBC; k[0] = 1; end
                1: begin d[7:0] = 8'h1C; k[0] = 1; end
                2: d[7:0] = 8'h00;
                3: d[7:0] = 8'hAA;
                default: ;
            endcase
            do_cycle($urandom_range(0, 199) == 0, $urandom_range(0, 7) != 0,
                     $urandom_range(0, 15) == 0, d, k, 2'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
